// File: rtl/johnson_decoder_pkg.sv
// Shared types and helpers for the Johnson-code decoder.
// Contents: FSM state enum, decode result struct, and width-generic
// Johnson pattern / decode / successor functions (code width passed at call).
package johnson_decoder_pkg;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned SEQ_LEN = 2 * WIDTH;
    localparam int unsigned CW      = $clog2(SEQ_LEN);
    localparam int unsigned MAX_W   = 16;
    localparam int unsigned MAX_CW  = 5;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } jdec_state_t;

    typedef struct packed {
        logic              legal;
        logic [MAX_CW-1:0] value;
    } jdec_dec_t;

    // Johnson word for sequence index k at width w: k ones filling from the
    // LSB for k<=w, then zeros filling from the LSB (2w-k ones remain on top).
    function automatic logic [MAX_W-1:0] johnson_pattern(input logic [MAX_CW-1:0] k,
                                                         input int unsigned w);
        logic [MAX_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (32'(k) <= w) p[i] = (i < 32'(k));
                else             p[i] = (i >= 32'(k) - w);
            end
        end
        return p;
    endfunction

    // Decode by popcount; a code is legal only if it regenerates itself.
    function automatic jdec_dec_t johnson_to_bin(input logic [MAX_W-1:0] code,
                                                 input int unsigned w);
        int unsigned pop;
        logic        msb;
        jdec_dec_t   d;
        pop = 0;
        msb = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                pop = pop + 32'(code[i]);
                if (i == w - 1) msb = code[i];
            end
        end
        d.value = msb ? MAX_CW'(2 * w - pop) : MAX_CW'(pop);
        d.legal = (code == johnson_pattern(d.value, w));
        return d;
    endfunction

    // Next index in the 2w-long sequence, wrapping to 0.
    function automatic logic [MAX_CW-1:0] johnson_succ(input logic [MAX_CW-1:0] value,
                                                       input int unsigned w);
        return (32'(value) == 2 * w - 1) ? '0 : value + MAX_CW'(1);
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson-code source (master) and the decoder (slave).
// Signals: code_in/code_valid toward the decoder; count, count_valid,
// illegal, seq_err, locked, err_cnt back from it.
interface johnson_decoder_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] code_in;
    logic             code_valid;
    logic [CW-1:0]    count;
    logic             count_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [7:0]       err_cnt;

    modport master (
        output code_in, code_valid,
        input  count, count_valid, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  code_in, code_valid,
        output count, count_valid, illegal, seq_err, locked, err_cnt
    );

endinterface

// File: rtl/johnson_decoder_code_check.sv
// Combinational Johnson decode of one code word.
// Ports: code_in (WIDTH) in; legal_c, value_c (clog2(2*WIDTH)) out.
module johnson_decoder_code_check
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]            code_in,
    output logic                        legal_c,
    output logic [$clog2(2*WIDTH)-1:0]  value_c
);

    localparam int unsigned VW = $clog2(2 * WIDTH);

    jdec_dec_t dec_c;

    always_comb begin
        dec_c   = johnson_to_bin(MAX_W'(code_in), WIDTH);
        legal_c = dec_c.legal;
        value_c = VW'(dec_c.value);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes sampled codes to binary, flags illegal
// words and out-of-sequence steps, and tracks lock to a running sequence.
// Ports: clk; rst (active-low, synchronous); bus (johnson_decoder_if.slave)
//   carrying code_in/code_valid in and count/count_valid/illegal/seq_err/
//   locked/err_cnt out. All outputs registered.
// Build option: define JDEC_ERR_CNT_EN to build the saturating error counter;
//   otherwise err_cnt is tied to zero.
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_N     = 3,
    parameter int unsigned UNLOCK_N   = 2,
    parameter int unsigned ALLOW_HOLD = 0
) (
    input  logic                clk,
    input  logic                rst,
    johnson_decoder_if.slave    bus
);

    localparam int unsigned VW = $clog2(2 * WIDTH);
    localparam int unsigned GW = $clog2(LOCK_N + 1);
    localparam int unsigned BW = $clog2(UNLOCK_N + 1);

    jdec_state_t   state_q;
    logic [VW-1:0] prev_q;
    logic [VW-1:0] count_q;
    logic          count_valid_q;
    logic          illegal_q;
    logic          seq_err_q;
    logic          locked_q;
    logic [GW-1:0] good_q;   // successor steps seen since entering ACQUIRE
    logic [BW-1:0] bad_q;    // consecutive bad samples while LOCKED

    logic          legal_c;
    logic [VW-1:0] value_c;
    logic [VW-1:0] succ_c;
    logic          step_ok_c;
    logic          hold_ok_c;

    johnson_decoder_code_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .code_in (bus.code_in),
        .legal_c (legal_c),
        .value_c (value_c)
    );

    // Expected next index and whether this sample advances/holds the sequence.
    always_comb begin
        succ_c    = VW'(johnson_succ(MAX_CW'(prev_q), WIDTH));
        step_ok_c = legal_c && (value_c == succ_c);
        hold_ok_c = legal_c && (ALLOW_HOLD != 0) && (value_c == prev_q);
    end

    // Lock FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= UNLOCKED;
            prev_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            count_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            if (bus.code_valid) begin
                if (legal_c) begin
                    count_q       <= value_c;
                    count_valid_q <= 1'b1;
                    prev_q        <= value_c;
                end else begin
                    illegal_q     <= 1'b1;
                end

                unique case (state_q)
                    UNLOCKED: begin
                        if (legal_c) begin
                            state_q <= ACQUIRE;
                            good_q  <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (!legal_c) begin
                            state_q <= UNLOCKED;
                        end else if (step_ok_c) begin
                            if (32'(good_q) + 32'd1 >= LOCK_N) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                good_q   <= '0;
                                bad_q    <= '0;
                            end else begin
                                good_q <= good_q + GW'(1);
                            end
                        end else begin
                            // Legal but out of order: restart the run here.
                            good_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (step_ok_c || hold_ok_c) begin
                            bad_q <= '0;
                        end else begin
                            seq_err_q <= legal_c;
                            if (32'(bad_q) + 32'd1 >= UNLOCK_N) begin
                                state_q  <= UNLOCKED;
                                locked_q <= 1'b0;
                                bad_q    <= '0;
                            end else begin
                                bad_q <= bad_q + BW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count       = count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.locked      = locked_q;

`ifdef JDEC_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_event_c;

    // Same conditions that raise the illegal / seq_err pulses.
    always_comb begin
        err_event_c = bus.code_valid &&
                      (!legal_c || ((state_q == LOCKED) && !(step_ok_c || hold_ok_c)));
    end

    // Saturating event counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_event_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: two instances (hold disallowed / allowed) share
// one stimulus stream; a table-driven reference model predicts every output.
module tb_johnson_decoder;

    localparam int unsigned LOCK_N   = 3;
    localparam int unsigned UNLOCK_N = 2;
`ifdef JDEC_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int M_UNL = 0;
    localparam int M_ACQ = 1;
    localparam int M_LCK = 2;

    typedef struct {
        int mode;
        int steps;
        int bad;
        int prev;
        int count;
        int cv;
        int ill;
        int se;
        int errs;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       valid = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [3:0] jmap [8];
    mdl_t m0;
    mdl_t m1;

    johnson_decoder_if #(.WIDTH(4)) if0 ();
    johnson_decoder_if #(.WIDTH(4)) if1 ();

    assign if0.code_in    = code;
    assign if0.code_valid = valid;
    assign if1.code_in    = code;
    assign if1.code_valid = valid;

    johnson_decoder #(.WIDTH(4), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ALLOW_HOLD(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    johnson_decoder #(.WIDTH(4), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ALLOW_HOLD(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    function automatic int lookup(input logic [3:0] c);
        for (int k = 0; k < 8; k++)
            if (jmap[k] == c) return k;
        return -1;
    endfunction

    task automatic model_step(inout mdl_t m, input logic r, input logic [3:0] c,
                              input logic v, input bit hold);
        int k;
        int nxt;
        bit legal;
        if (!r) begin
            m = '{default: 0};
            return;
        end
        m.cv = 0; m.ill = 0; m.se = 0;
        if (!v) return;
        k = lookup(c);
        legal = (k >= 0);
        nxt = (m.prev + 1) % 8;
        if (legal) begin m.cv = 1; m.count = k; end
        else m.ill = 1;
        case (m.mode)
            M_UNL: if (legal) begin m.mode = M_ACQ; m.steps = 0; end
            M_ACQ: begin
                if (!legal) m.mode = M_UNL;
                else if (k == nxt) begin
                    m.steps++;
                    if (m.steps >= LOCK_N) begin m.mode = M_LCK; m.bad = 0; end
                end else m.steps = 0;
            end
            default: begin
                if (legal && (k == nxt || (hold && k == m.prev))) m.bad = 0;
                else begin
                    m.se = legal ? 1 : 0;
                    m.bad++;
                    if (m.bad >= UNLOCK_N) begin m.mode = M_UNL; m.bad = 0; end
                end
            end
        endcase
        if (legal) m.prev = k;
        if (ERR_EN && (m.ill != 0 || m.se != 0) && m.errs < 255) m.errs++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("d0.count",       32'(if0.count),       m0.count);
        chk("d0.count_valid", 32'(if0.count_valid), m0.cv);
        chk("d0.illegal",     32'(if0.illegal),     m0.ill);
        chk("d0.seq_err",     32'(if0.seq_err),     m0.se);
        chk("d0.locked",      32'(if0.locked),      (m0.mode == M_LCK) ? 1 : 0);
        chk("d0.err_cnt",     32'(if0.err_cnt),     m0.errs);
        chk("d1.count",       32'(if1.count),       m1.count);
        chk("d1.count_valid", 32'(if1.count_valid), m1.cv);
        chk("d1.illegal",     32'(if1.illegal),     m1.ill);
        chk("d1.seq_err",     32'(if1.seq_err),     m1.se);
        chk("d1.locked",      32'(if1.locked),      (m1.mode == M_LCK) ? 1 : 0);
        chk("d1.err_cnt",     32'(if1.err_cnt),     m1.errs);
    endtask

    task automatic step(input logic r, input logic [3:0] c, input logic v);
        @(negedge clk);
        rst = r; code = c; valid = v;
        @(posedge clk);
        #1;
        model_step(m0, r, c, v, 1'b0);
        model_step(m1, r, c, v, 1'b1);
        compare_all();
    endtask

    initial begin
        int cur;
        int r;
        logic [3:0] c;
        jmap = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        m0 = '{default: 0};
        m1 = '{default: 0};

        // Reset dominates a valid legal code.
        step(1'b0, 4'b0011, 1'b1);
        step(1'b0, 4'b0011, 1'b1);
        chk("rst.count",  32'(if0.count),  0);
        chk("rst.locked", 32'(if0.locked), 0);

        // Acquire and lock.
        step(1'b1, 4'b0000, 1'b1);
        chk("acq.count0", 32'(if0.count), 0);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        chk("acq.unlocked3", 32'(if0.locked), 0);
        step(1'b1, 4'b0111, 1'b1);
        chk("acq.locked4", 32'(if0.locked), 1);
        chk("acq.count3",  32'(if0.count),  3);

        // Full wrap while locked.
        for (int k = 4; k < 9; k++) step(1'b1, jmap[k % 8], 1'b1);
        chk("wrap.count0", 32'(if0.count),   0);
        chk("wrap.noerr",  32'(if0.seq_err), 0);
        chk("wrap.locked", 32'(if0.locked),  1);

        // Illegal then out-of-order drops lock.
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        step(1'b1, 4'b0111, 1'b1);
        step(1'b1, 4'b1010, 1'b1);
        chk("bad.illegal", 32'(if0.illegal), 1);
        chk("bad.hold3",   32'(if0.count),   3);
        step(1'b1, 4'b1110, 1'b1);
        chk("bad.seq_err", 32'(if0.seq_err), 1);
        chk("bad.unlock",  32'(if0.locked),  0);
        chk("bad.errcnt",  32'(if0.err_cnt), ERR_EN ? 2 : 0);

        // Relock at 0011, then repeat it.
        step(1'b1, 4'b1000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        chk("hold.locked", 32'(if0.locked), 1);
        step(1'b1, 4'b0011, 1'b1);
        chk("hold.seq_err0", 32'(if0.seq_err), 1);
        chk("hold.seq_err1", 32'(if1.seq_err), 0);

        // Randomized mix of successors, holds, idles and arbitrary words.
        cur = 2;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                cur = (cur + 1) % 8;
                step(1'b1, jmap[cur], 1'b1);
            end else if (r == 6) begin
                c = 4'($urandom);
                if (lookup(c) >= 0) cur = lookup(c);
                step(1'b1, c, 1'b1);
            end else if (r == 7) begin
                step(1'b1, 4'($urandom), 1'b0);
            end else begin
                step(1'b1, jmap[cur], 1'b1);
            end
        end

        // Error counter saturation.
        for (int n = 0; n < 300; n++) step(1'b1, 4'b1010, 1'b1);
        chk("sat.errcnt", 32'(if0.err_cnt), ERR_EN ? 255 : 0);

        // Reset mid-stream while locked.
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        step(1'b1, 4'b0111, 1'b1);
        chk("mid.locked", 32'(if0.locked), 1);
        step(1'b0, 4'b1111, 1'b1);
        chk("mid.unlocked", 32'(if0.locked),  0);
        chk("mid.count",    32'(if0.count),   0);
        chk("mid.errcnt",   32'(if0.err_cnt), 0);
        step(1'b1, 4'b1111, 1'b1);
        chk("post.count", 32'(if0.count), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
